// File: rtl/exp_golomb_decoder.sv
// exp_golomb_decoder
// Serial-to-parallel order-0 Exp-Golomb decoder. One code bit is consumed
// per cycle while valid_i is high: the zero prefix is counted, the suffix
// (leading 1 included) is gathered, and the decoded value is presented as a
// registered word together with a one-cycle valid_o pulse.
//
// Optional feature macro: EXP_GOLOMB_DEC_ERR_EN
//   defined   : a zero arriving when the prefix already holds DATA_WIDTH zeros
//               is a prefix overflow; err_o pulses, the codeword is dropped
//               and the FSM returns to IDLE.
//   undefined : err_o is tied low and the prefix counter saturates at
//               DATA_WIDTH, so surplus zeros are ignored.
module exp_golomb_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  dft_tm_i,
    input  logic                  dt_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] dt_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  err_o
);

    // FSM encoding
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] PREFIX = 2'b01;
    localparam logic [1:0] SUFFIX = 2'b10;

    // Counter constants
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ZCNT_MAX = ADDR_WIDTH'(DATA_WIDTH);

    // Shift-register constants (x is DATA_WIDTH+1 bits wide)
    localparam logic [DATA_WIDTH:0]   SHREG_ONE = {{DATA_WIDTH{1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DT_ZERO   = {DATA_WIDTH{1'b0}};

    // Recover v from x = v + 1. The subtraction is done at the full x width;
    // since x never exceeds 2^DATA_WIDTH the result always fits DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] decode_value(input logic [DATA_WIDTH:0] x);
        return DATA_WIDTH'(x - SHREG_ONE);
    endfunction

    // Test mode forces the internal reset inactive so scan can clock freely.
    logic rstn_b;
    assign rstn_b = dft_tm_i ? 1'b1 : rstn_i;

    // State registers and their next-state values
    logic [1:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] zcnt_q,    zcnt_d;
    logic [ADDR_WIDTH-1:0] rem_q,     rem_d;
    logic [DATA_WIDTH:0]   shreg_q,   shreg_d;
    logic [DATA_WIDTH-1:0] dt_q,      dt_d;
    logic                  valid_q,   valid_d;
    logic                  err_q,     err_d;

    // Suffix register with the incoming bit appended
    logic [DATA_WIDTH:0]   shifted_s;
    assign shifted_s = {shreg_q[DATA_WIDTH-1:0], dt_i};

    // Next-state logic: prefix counting, suffix gathering and result load
    always_comb begin
        state_d = state_q;
        zcnt_d  = zcnt_q;
        rem_d   = rem_q;
        shreg_d = shreg_q;
        dt_d    = dt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (valid_i) begin
            case (state_q)
                IDLE: begin
                    if (dt_i) begin
                        // Single-bit codeword "1" is value 0
                        dt_d    = DT_ZERO;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        zcnt_d  = CNT_ONE;
                        state_d = PREFIX;
                    end
                end

                PREFIX: begin
                    if (dt_i) begin
                        // Leading 1 of x; zcnt more bits follow it
                        shreg_d = SHREG_ONE;
                        rem_d   = zcnt_q;
                        state_d = SUFFIX;
                    end else if (zcnt_q == ZCNT_MAX) begin
`ifdef EXP_GOLOMB_DEC_ERR_EN
                        // Prefix longer than any legal codeword: drop it
                        err_d   = 1'b1;
                        zcnt_d  = CNT_ZERO;
                        state_d = IDLE;
`else
                        // Saturate; surplus zeros are ignored
                        zcnt_d  = zcnt_q;
                        state_d = PREFIX;
`endif
                    end else begin
                        zcnt_d  = zcnt_q + CNT_ONE;
                        state_d = PREFIX;
                    end
                end

                SUFFIX: begin
                    shreg_d = shifted_s;
                    rem_d   = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        // Final suffix bit: publish the result this edge
                        dt_d    = decode_value(shifted_s);
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SUFFIX;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean IDLE
                    state_d = IDLE;
                    zcnt_d  = CNT_ZERO;
                    rem_d   = CNT_ZERO;
                    shreg_d = SHREG_ONE;
                end
            endcase
        end else begin
            // No code bit this cycle: every register holds
            state_d = state_q;
        end
    end

    // Registers, asynchronously cleared by the (test-mode gated) reset
    always_ff @(posedge clk_i or negedge rstn_b) begin
        if (!rstn_b) begin
            state_q <= IDLE;
            zcnt_q  <= CNT_ZERO;
            rem_q   <= CNT_ZERO;
            shreg_q <= SHREG_ONE;
            dt_q    <= DT_ZERO;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            zcnt_q  <= zcnt_d;
            rem_q   <= rem_d;
            shreg_q <= shreg_d;
            dt_q    <= dt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dt_o    = dt_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != IDLE);
`ifdef EXP_GOLOMB_DEC_ERR_EN
    assign err_o   = err_q;
`else
    // Overflow reporting disabled: the err flop never leaves 0
    assign err_o   = err_q & 1'b0;
`endif

endmodule

// File: doc/exp_golomb_decoder.md
# exp_golomb_decoder

Serial-to-parallel order-0 Exp-Golomb decoder: the receive-side counterpart of the team's Exp-Golomb coder. It consumes one code bit per cycle while `valid_i` is high. It counts the zero prefix, gathers the suffix, and presents the decoded value as a registered `DATA_WIDTH`-bit word with a one-cycle `valid_o` pulse. It sits directly on the coder's serial output (`dt_o`/`valid_o`) in loopback and system builds.

## Interface
- `DATA_WIDTH`, 8: width of decoded value; maximum prefix length is `DATA_WIDTH`.
- `ADDR_WIDTH`, 4: width of the zero/remaining-bit counters; must satisfy 2^ADDR_WIDTH > DATA_WIDTH.
- `clk_i` (input, 1): the single clock; all state changes on its rising edge.
- `rstn_i` (input, 1): reset, asynchronous, active-low.
- `dft_tm_i` (input, 1): test mode. When it is 1, internal reset is forced inactive (`rstn_b = dft_tm_i ? 1 : rstn_i`).
- `dt_i` (input, 1): serial code bit, MSB-first.
- `valid_i` (input, 1): `dt_i` is sampled only when this is 1. Gaps (`valid_i`=0) are allowed anywhere.
- `dt_o` (output, DATA_WIDTH): last decoded value; holds until the next decode completes.
- `valid_o` (output, 1): one-cycle pulse, the cycle after a codeword's final bit is sampled.
- `busy_o` (output, 1): 1 while a codeword is partially received (state ≠ IDLE).
- `err_o` (output, 1): one-cycle pulse on prefix overflow (see Configuration).

## Operation
- Codeword for value v: x = v+1 (DATA_WIDTH+1 bits); N = index of x's MSB. The codeword is N zeros, then N+1 bits of x MSB-first (the leading bit is the 1). Length is 2N+1.
- FSM states are IDLE, PREFIX and SUFFIX. Registers:
  - `zcnt` (ADDR_WIDTH bits)
  - `rem` (ADDR_WIDTH bits)
  - `shreg` (DATA_WIDTH+1 bits)
- IDLE:
  - `valid_i`&`dt_i`=1 → N=0 codeword. Load `dt_o`=0, pulse `valid_o`, stay IDLE.
  - `valid_i`&`dt_i`=0 → `zcnt`=1, go to PREFIX.
- PREFIX:
  - `valid_i`&`dt_i`=0 → `zcnt`++, subject to the overflow rule.
  - `valid_i`&`dt_i`=1 → `shreg`=1, `rem`=`zcnt`, go to SUFFIX.
- SUFFIX, on `valid_i`: `shreg`={`shreg`[DATA_WIDTH-1:0], `dt_i`} and `rem`--.
  - When `rem`==1 on that sample, the codeword is complete.
  - On completion: `dt_o` ← (shifted `shreg` − 1)[DATA_WIDTH-1:0], `valid_o` pulses, go to IDLE.
- Arithmetic: the subtraction is DATA_WIDTH+1 bits wide. The result always fits DATA_WIDTH, since x ≤ 2^DATA_WIDTH.
- `valid_i`=0 in any state: hold all registers. `valid_o`/`err_o` deassert after their pulse cycle.
- Back-to-back codewords: the bit sampled in the cycle `valid_o` is high belongs to the next codeword and is processed normally. No dead cycle is allowed.
- `busy_o` is combinational from state: 0 in IDLE, 1 in PREFIX/SUFFIX.

## Timing
- Reset values: `dt_o`=0, `valid_o`=0, `busy_o`=0, `err_o`=0, state=IDLE, `zcnt`=`rem`=0, `shreg`=1.
- Reset asserted mid-codeword aborts it immediately. No `valid_o` is produced, and decoding restarts from IDLE after release.
- Latency: `valid_o`/`dt_o` update on the clock edge that samples the final code bit. They are visible in the following cycle, i.e. 1 cycle after the last bit.
- Throughput: one bit per cycle; one result per 2N+1 valid bits.
- `dt_o` is registered; there is no combinational path from `dt_i` to any output except through state to `busy_o`.

## Configuration
- Macro `EXP_GOLOMB_DEC_ERR_EN` is defined:
  - A zero sampled in PREFIX when `zcnt`==DATA_WIDTH is an overflow.
  - Overflow → `err_o` pulses for one cycle, `zcnt` is cleared, and the FSM returns to IDLE. The offending bit is discarded, and `dt_o` is unchanged.
- Macro not defined:
  - `err_o` is tied 0.
  - `zcnt` saturates at DATA_WIDTH; extra zeros are ignored and decoding continues when the 1 arrives.

## Test plan
- After reset, drive `valid_i`=1 with bit sequence 1 → `valid_o` pulse next cycle, `dt_o`=0. All outputs read 0 before stimulus.
- Sequence 0,0,1,0,0 (v=3) → `busy_o`=1 from the 2nd bit through the 5th; `valid_o` 1 cycle after the 5th bit, `dt_o`=3.
- 8 zeros, 1, then 8 zeros (17 bits) → `dt_o`=255, `valid_o` single pulse.
- Back-to-back 1 | 0,1,0 | 0,1,1 with `valid_i` held high → three pulses with `dt_o`=0, 1, 2. No gap cycle is needed.
- Codeword 0,0,1,0,1 (v=4) with `valid_i` low for 3 cycles after bit 3 → `dt_o`=4, with the pulse delayed exactly by the gap. Same sequence with `rstn_i` pulsed low after bit 3 → no `valid_o`, and a following 1 decodes to 0.
- With `EXP_GOLOMB_DEC_ERR_EN`, send 9 zeros → `err_o` pulse after the 9th, FSM in IDLE, then a following 1 decodes to 0. Without the macro, send 9 zeros, 1, 8 zeros → `dt_o`=255 and `err_o` stays 0.
